axi4_lite_arb_2x1: RTL and testbench
====================================

AXI4_LITE_ARB_2X1 -- requirements
Module: axi4_lite_arb_2x1

Interface
REQ-001 SHALL have parameter ADDR_BIT_WIDTH, default 32, address bit width of all three ports.
REQ-002 SHALL have parameter DATA_BIT_WIDTH, default 32, data bit width of all three ports (multiple of 8).
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port s0_if, axi4_lite_if.slv_port, -, requester 0 (highest initial priority).
REQ-006 SHALL have port s1_if, axi4_lite_if.slv_port, -, requester 1.
REQ-007 SHALL have port m_if, axi4_lite_if.mst_port, -, shared downstream AXI4-Lite slave.

Function
REQ-008 SHALL run two independent arbiters: write (AW/W/B) and read (AR/R); a write and a read MAY be in flight simultaneously from different or the same requester.
REQ-009 Write FSM SHALL have states W_IDLE, W_ADDR_DATA, W_RESP; read FSM SHALL have states R_IDLE, R_ADDR, R_DATA.
REQ-010 Write request from requester n SHALL be sn.awvalid | sn.wvalid; read request SHALL be sn.arvalid.
REQ-011 In *_IDLE, requests SHALL be sampled at the clock edge and the grant registered; with any request present, the FSM SHALL move to W_ADDR_DATA / R_ADDR on that edge. With no request, it SHALL stay idle.
REQ-012 Grant latency SHALL be exactly 1 cycle: m_if valid signals may assert no earlier than the cycle after the request is first seen in idle.
REQ-013 In W_ADDR_DATA, m_if AW and W channels SHALL be combinationally muxed from the granted requester; each channel SHALL be forwarded until its own handshake completes (aw_done, w_done flags), then its m_if valid and the granted ready SHALL be held 0.
REQ-014 When AW and W handshakes are both complete (same or different cycles), FSM SHALL go to W_RESP; B SHALL be muxed to the granted requester. On bvalid & bready it SHALL return to W_IDLE.
REQ-015 In R_ADDR, AR SHALL be muxed from the grantee; on arvalid & arready, go to R_DATA. In R_DATA, R SHALL be muxed to the grantee; on rvalid & rready, return to R_IDLE.
REQ-016 The non-granted requester SHALL see awready, wready, bvalid, arready, rvalid = 0; its bresp, rdata and rresp SHALL be 0.
REQ-017 m_if.awprot/arprot/wstrb/data SHALL pass through unmodified from the grantee; when idle, all m_if outputs SHALL be 0.
REQ-018 Grant SHALL be held until the transaction's response handshake completes; no preemption.
REQ-019 Only one outstanding transaction per channel direction SHALL exist at any time.

Reset
REQ-020 On rst=1 at a clock edge, both FSMs SHALL go to idle and aw_done/w_done SHALL clear, regardless of state (including mid-transaction). The round-robin pointers SHALL be set to "last grant = 1".
REQ-021 During and after reset, until a new grant, all valid/ready outputs on all ports SHALL be 0, and all data/resp outputs SHALL be 0.
REQ-022 An in-flight transaction aborted by reset SHALL NOT be completed or replayed.

Configuration
REQ-023 With macro AXI4_LITE_ARB_RR_EN defined, each arbiter SHALL use round-robin: on simultaneous requests, grant the requester not granted last; the pointer updates on each grant.
REQ-024 Without AXI4_LITE_ARB_RR_EN, each arbiter SHALL use fixed priority: requester 0 always wins simultaneous requests, and no pointer is implemented.

Verification
REQ-025 Single write: s0 writes 0xDEADBEEF to 0x10, slave ready immediately -> m_if.awvalid first asserts 1 cycle after s0.awvalid; s0 sees bvalid with OKAY; s1 sees no ready.
REQ-026 Simultaneous writes, RR enabled: s0 and s1 write in the same cycle -> s0 is served first, then s1; repeated contention alternates grants 0,1,0,1. With RR disabled, s0 always wins.
REQ-027 Split AW/W: s1 gives awvalid at cycle 0 and wvalid at cycle 3; slave awready=1, wready delayed 2 cycles -> one m_if write; W_RESP entered only after both handshakes complete.
REQ-028 Concurrent read/write: s0 write to 0x4 and s1 read from 0x8 in the same cycle; slave returns rdata 0x12345678 -> both complete independently; s1 gets 0x12345678, and s0's rdata stays 0.
REQ-029 Reset mid-op: assert rst while in W_RESP with bvalid pending -> next cycle, all valids are 0 and the FSMs are idle; a following s1 read completes normally.
REQ-030 Backpressure: s0 read with rready=0 for 5 cycles while slave holds rvalid -> grant is held, s1 read waits, and rdata is stable until the handshake.

Source files
------------

// File: rtl/axi4_lite_arb_2x1_if.sv
// AXI4-Lite channel bundle shared by the 2x1 arbiter ports.
// slv_port is the view of a block that accepts requests; mst_port is the view of a block that issues them.
interface axi4_lite_if #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32
);
  logic [ADDR_BIT_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [DATA_BIT_WIDTH-1:0]   wdata;
  logic [DATA_BIT_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [ADDR_BIT_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [DATA_BIT_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport slv_port (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport mst_port (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_arb_2x1.sv
// Two-requester AXI4-Lite arbiter with independent write (AW/W/B) and read (AR/R) arbiters.
// Fixed priority (requester 0 wins) by default; define AXI4_LITE_ARB_RR_EN for round-robin.
module axi4_lite_arb_2x1 #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  axi4_lite_if.slv_port   s0_if,
  axi4_lite_if.slv_port   s1_if,
  axi4_lite_if.mst_port   m_if
);
  typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA}      r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic     w_gnt_q, w_gnt_d, r_gnt_q, r_gnt_d;
  logic     aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic [1:0] w_req, r_req;
  logic       w_pick, r_pick;

  logic                        sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
  logic [ADDR_BIT_WIDTH-1:0]   sel_awaddr, sel_araddr;
  logic [2:0]                  sel_awprot, sel_arprot;
  logic [DATA_BIT_WIDTH-1:0]   sel_wdata;
  logic [DATA_BIT_WIDTH/8-1:0] sel_wstrb;

  logic                      awready_g, wready_g, bvalid_g, arready_g, rvalid_g;
  logic [1:0]                bresp_g, rresp_g;
  logic [DATA_BIT_WIDTH-1:0] rdata_g;

  assign w_req = {s1_if.awvalid | s1_if.wvalid, s0_if.awvalid | s0_if.wvalid};
  assign r_req = {s1_if.arvalid, s0_if.arvalid};

  // The grant register doubles as the "last granted" pointer; it resets to 1 so requester 0 wins first.
`ifdef AXI4_LITE_ARB_RR_EN
  assign w_pick = (&w_req) ? ~w_gnt_q : w_req[1];
  assign r_pick = (&r_req) ? ~r_gnt_q : r_req[1];
`else
  assign w_pick = ~w_req[0];
  assign r_pick = ~r_req[0];
`endif

  always_comb begin
    sel_awvalid = w_gnt_q ? s1_if.awvalid : s0_if.awvalid;
    sel_awaddr  = w_gnt_q ? s1_if.awaddr  : s0_if.awaddr;
    sel_awprot  = w_gnt_q ? s1_if.awprot  : s0_if.awprot;
    sel_wvalid  = w_gnt_q ? s1_if.wvalid  : s0_if.wvalid;
    sel_wdata   = w_gnt_q ? s1_if.wdata   : s0_if.wdata;
    sel_wstrb   = w_gnt_q ? s1_if.wstrb   : s0_if.wstrb;
    sel_bready  = w_gnt_q ? s1_if.bready  : s0_if.bready;
    sel_arvalid = r_gnt_q ? s1_if.arvalid : s0_if.arvalid;
    sel_araddr  = r_gnt_q ? s1_if.araddr  : s0_if.araddr;
    sel_arprot  = r_gnt_q ? s1_if.arprot  : s0_if.arprot;
    sel_rready  = r_gnt_q ? s1_if.rready  : s0_if.rready;
  end

  // Write arbiter: next state, downstream AW/W/B drive, and return path to the grantee.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    w_state_d   = w_state_q;
    w_gnt_d     = w_gnt_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awready_g   = 1'b0;
    wready_g    = 1'b0;
    bvalid_g    = 1'b0;
    bresp_g     = '0;
    m_if.awvalid = 1'b0;
    m_if.awaddr  = '0;
    m_if.awprot  = '0;
    m_if.wvalid  = 1'b0;
    m_if.wdata   = '0;
    m_if.wstrb   = '0;
    m_if.bready  = 1'b0;

    unique case (w_state_q)
      W_IDLE: begin
        if (|w_req) begin
          w_gnt_d   = w_pick;
          w_state_d = W_ADDR_DATA;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_ADDR_DATA: begin
        if (!aw_done_q) begin
          m_if.awvalid = sel_awvalid;
          m_if.awaddr  = sel_awaddr;
          m_if.awprot  = sel_awprot;
          awready_g    = m_if.awready;
        end
        if (!w_done_q) begin
          m_if.wvalid = sel_wvalid;
          m_if.wdata  = sel_wdata;
          m_if.wstrb  = sel_wstrb;
          wready_g    = m_if.wready;
        end
        aw_done_d = aw_done_q | (awready_g & sel_awvalid);
        w_done_d  = w_done_q  | (wready_g  & sel_wvalid);
        if (aw_done_d && w_done_d) w_state_d = W_RESP;
      end
      W_RESP: begin
        m_if.bready = sel_bready;
        bvalid_g    = m_if.bvalid;
        bresp_g     = m_if.bresp;
        if (m_if.bvalid && sel_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase

    s0_if.awready = awready_g & ~w_gnt_q;
    s0_if.wready  = wready_g  & ~w_gnt_q;
    s0_if.bvalid  = bvalid_g  & ~w_gnt_q;
    s0_if.bresp   = w_gnt_q ? 2'b00 : bresp_g;
    s1_if.awready = awready_g & w_gnt_q;
    s1_if.wready  = wready_g  & w_gnt_q;
    s1_if.bvalid  = bvalid_g  & w_gnt_q;
    s1_if.bresp   = w_gnt_q ? bresp_g : 2'b00;
  end

  // Read arbiter: next state, downstream AR/R drive, and return path to the grantee.
  always_comb begin
    r_state_d    = r_state_q;
    r_gnt_d      = r_gnt_q;
    arready_g    = 1'b0;
    rvalid_g     = 1'b0;
    rdata_g      = '0;
    rresp_g      = '0;
    m_if.arvalid = 1'b0;
    m_if.araddr  = '0;
    m_if.arprot  = '0;
    m_if.rready  = 1'b0;

    unique case (r_state_q)
      R_IDLE: begin
        if (|r_req) begin
          r_gnt_d   = r_pick;
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_if.arvalid = sel_arvalid;
        m_if.araddr  = sel_araddr;
        m_if.arprot  = sel_arprot;
        arready_g    = m_if.arready;
        if (sel_arvalid && m_if.arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        m_if.rready = sel_rready;
        rvalid_g    = m_if.rvalid;
        rdata_g     = m_if.rdata;
        rresp_g     = m_if.rresp;
        if (m_if.rvalid && sel_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase

    s0_if.arready = arready_g & ~r_gnt_q;
    s0_if.rvalid  = rvalid_g  & ~r_gnt_q;
    s0_if.rdata   = r_gnt_q ? '0 : rdata_g;
    s0_if.rresp   = r_gnt_q ? 2'b00 : rresp_g;
    s1_if.arready = arready_g & r_gnt_q;
    s1_if.rvalid  = rvalid_g  & r_gnt_q;
    s1_if.rdata   = r_gnt_q ? rdata_g : '0;
    s1_if.rresp   = r_gnt_q ? rresp_g : 2'b00;
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      w_gnt_q   <= 1'b1;
      r_gnt_q   <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      w_gnt_q   <= w_gnt_d;
      r_gnt_q   <= r_gnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule

// File: tb/tb_axi4_lite_arb_2x1.sv
// Directed bench for axi4_lite_arb_2x1: drives both requesters and plays the downstream slave by hand.
module tb_axi4_lite_arb_2x1;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   aw_hs_cnt = 0;
  int   hs_base;

`ifdef AXI4_LITE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  axi4_lite_if s0 ();
  axi4_lite_if s1 ();
  axi4_lite_if m ();

  axi4_lite_arb_2x1 dut (
    .clk   (clk),
    .rst   (rst),
    .s0_if (s0),
    .s1_if (s1),
    .m_if  (m)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (m.awvalid && m.awready) aw_hs_cnt <= aw_hs_cnt + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One contended write round: starts in idle with requests present, ends back in idle.
  task automatic serve_write(input string tag, input logic [31:0] exp_addr, input logic exp_gnt);
    sample;
    check({tag, "_idle_awvalid"}, m.awvalid, 1'b0);
    tick;
    sample;
    check({tag, "_awaddr"}, m.awaddr, exp_addr);
    check({tag, "_s0_awready"}, s0.awready, !exp_gnt);
    check({tag, "_s1_awready"}, s1.awready, exp_gnt);
    tick;
    if (exp_gnt) begin s1.awvalid = 1'b0; s1.wvalid = 1'b0; end
    else begin s0.awvalid = 1'b0; s0.wvalid = 1'b0; end
    m.bvalid = 1'b1;
    sample;
    check({tag, "_s0_bvalid"}, s0.bvalid, !exp_gnt);
    check({tag, "_s1_bvalid"}, s1.bvalid, exp_gnt);
    tick;
    m.bvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s0.awaddr = '0; s0.awprot = '0; s0.awvalid = 0; s0.wdata = '0; s0.wstrb = '0; s0.wvalid = 0;
    s0.bready = 0; s0.araddr = '0; s0.arprot = '0; s0.arvalid = 0; s0.rready = 0;
    s1.awaddr = '0; s1.awprot = '0; s1.awvalid = 0; s1.wdata = '0; s1.wstrb = '0; s1.wvalid = 0;
    s1.bready = 0; s1.araddr = '0; s1.arprot = '0; s1.arvalid = 0; s1.rready = 0;
    m.awready = 0; m.wready = 0; m.bresp = '0; m.bvalid = 0;
    m.arready = 0; m.rdata = '0; m.rresp = '0; m.rvalid = 0;

    // Reset state
    repeat (3) tick;
    sample;
    check("rst_m_awvalid", m.awvalid, 1'b0);
    check("rst_m_arvalid", m.arvalid, 1'b0);
    check("rst_m_awaddr", m.awaddr, 32'h0);
    check("rst_m_wdata", m.wdata, 32'h0);
    check("rst_s0_awready", s0.awready, 1'b0);
    check("rst_s0_bvalid", s0.bvalid, 1'b0);
    check("rst_s1_arready", s1.arready, 1'b0);
    check("rst_s1_rdata", s1.rdata, 32'h0);

    // Single write from s0, slave ready immediately
    tick;
    rst = 1'b0;
    s0.awaddr = 32'h10; s0.awprot = 3'b010; s0.awvalid = 1; s0.wdata = 32'hDEADBEEF;
    s0.wstrb = 4'hF; s0.wvalid = 1; s0.bready = 1;
    m.awready = 1; m.wready = 1;
    sample;
    check("t1_lat_awvalid", m.awvalid, 1'b0);
    tick;
    sample;
    check("t1_awvalid", m.awvalid, 1'b1);
    check("t1_awaddr", m.awaddr, 32'h10);
    check("t1_awprot", m.awprot, 3'b010);
    check("t1_wdata", m.wdata, 32'hDEADBEEF);
    check("t1_wstrb", m.wstrb, 4'hF);
    check("t1_s0_awready", s0.awready, 1'b1);
    check("t1_s1_awready", s1.awready, 1'b0);
    check("t1_s1_wready", s1.wready, 1'b0);
    tick;
    s0.awvalid = 0; s0.wvalid = 0; m.bvalid = 1; m.bresp = 2'b00;
    sample;
    check("t1_resp_awvalid", m.awvalid, 1'b0);
    check("t1_resp_wvalid", m.wvalid, 1'b0);
    check("t1_bready", m.bready, 1'b1);
    check("t1_s0_bvalid", s0.bvalid, 1'b1);
    check("t1_s0_bresp", s0.bresp, 2'b00);
    check("t1_s1_bvalid", s1.bvalid, 1'b0);
    tick;
    m.bvalid = 0;
    sample;
    check("t1_done_s0_bvalid", s0.bvalid, 1'b0);

    // Contention: both write together, then s0 re-requests while s1 waits
    tick;
    s0.awaddr = 32'h20; s0.wdata = 32'h20; s0.awvalid = 1; s0.wvalid = 1;
    s1.awaddr = 32'h24; s1.wdata = 32'h24; s1.wstrb = 4'hF; s1.awvalid = 1; s1.wvalid = 1;
    s1.bready = 1;
    serve_write("c1", 32'h20, 1'b0);
    s0.awvalid = 1; s0.wvalid = 1;
    serve_write("c2", RR ? 32'h24 : 32'h20, RR);
    serve_write("c3", RR ? 32'h20 : 32'h24, !RR);

    // Split AW/W from s1 with delayed wready
    tick;
    hs_base = aw_hs_cnt;
    s1.awaddr = 32'h30; s1.awvalid = 1; s1.wvalid = 0;
    m.awready = 1; m.wready = 0;
    sample;
    check("t3_lat_awvalid", m.awvalid, 1'b0);
    tick;
    sample;
    check("t3_awvalid", m.awvalid, 1'b1);
    check("t3_awaddr", m.awaddr, 32'h30);
    check("t3_wvalid_early", m.wvalid, 1'b0);
    check("t3_s1_awready", s1.awready, 1'b1);
    tick;
    s1.awvalid = 0;
    sample;
    check("t3_aw_held_low", m.awvalid, 1'b0);
    check("t3_no_resp_c2", m.bready, 1'b0);
    tick;
    s1.wvalid = 1; s1.wdata = 32'hCAFEF00D;
    sample;
    check("t3_wvalid", m.wvalid, 1'b1);
    check("t3_wdata", m.wdata, 32'hCAFEF00D);
    check("t3_s1_wready_wait", s1.wready, 1'b0);
    tick;
    sample;
    check("t3_no_resp_c4", m.bready, 1'b0);
    tick;
    m.wready = 1;
    sample;
    check("t3_s1_wready", s1.wready, 1'b1);
    check("t3_no_resp_c5", m.bready, 1'b0);
    tick;
    s1.wvalid = 0; m.wready = 0; m.bvalid = 1;
    sample;
    check("t3_bready", m.bready, 1'b1);
    check("t3_s1_bvalid", s1.bvalid, 1'b1);
    check("t3_wvalid_done", m.wvalid, 1'b0);
    check("t3_one_aw_hs", aw_hs_cnt - hs_base, 1);
    tick;
    m.bvalid = 0;

    // Concurrent s0 write and s1 read
    s0.awaddr = 32'h4; s0.wdata = 32'h11; s0.awvalid = 1; s0.wvalid = 1;
    s1.araddr = 32'h8; s1.arvalid = 1; s1.rready = 1;
    m.awready = 1; m.wready = 1; m.arready = 1;
    sample;
    check("t4_lat_arvalid", m.arvalid, 1'b0);
    check("t4_lat_awvalid", m.awvalid, 1'b0);
    tick;
    sample;
    check("t4_awaddr", m.awaddr, 32'h4);
    check("t4_araddr", m.araddr, 32'h8);
    check("t4_arvalid", m.arvalid, 1'b1);
    check("t4_s1_arready", s1.arready, 1'b1);
    check("t4_s0_arready", s0.arready, 1'b0);
    check("t4_s1_awready", s1.awready, 1'b0);
    tick;
    s0.awvalid = 0; s0.wvalid = 0; s1.arvalid = 0;
    m.bvalid = 1; m.rvalid = 1; m.rdata = 32'h12345678;
    sample;
    check("t4_s1_rvalid", s1.rvalid, 1'b1);
    check("t4_s1_rdata", s1.rdata, 32'h12345678);
    check("t4_s0_rdata", s0.rdata, 32'h0);
    check("t4_s0_rvalid", s0.rvalid, 1'b0);
    check("t4_s0_bvalid", s0.bvalid, 1'b1);
    check("t4_s1_bvalid", s1.bvalid, 1'b0);
    tick;
    m.bvalid = 0; m.rvalid = 0;
    sample;
    check("t4_idle_s1_rdata", s1.rdata, 32'h0);
    check("t4_idle_s1_rvalid", s1.rvalid, 1'b0);
    check("t4_idle_s0_bvalid", s0.bvalid, 1'b0);

    // Reset while s0's write response is pending
    tick;
    s0.awaddr = 32'h40; s0.awvalid = 1; s0.wvalid = 1; s0.bready = 0;
    tick;
    tick;
    s0.awvalid = 0; s0.wvalid = 0; m.bvalid = 1;
    sample;
    check("t5_pending_bvalid", s0.bvalid, 1'b1);
    check("t5_pending_bready", m.bready, 1'b0);
    tick;
    rst = 1;
    tick;
    sample;
    check("t5_rst_s0_bvalid", s0.bvalid, 1'b0);
    check("t5_rst_bready", m.bready, 1'b0);
    check("t5_rst_awvalid", m.awvalid, 1'b0);
    check("t5_rst_arvalid", m.arvalid, 1'b0);
    check("t5_rst_s1_rvalid", s1.rvalid, 1'b0);
    tick;
    rst = 0; m.bvalid = 0; s0.bready = 1;
    s1.araddr = 32'h50; s1.arvalid = 1; s1.rready = 1; m.arready = 1;
    sample;
    check("t5_lat_arvalid", m.arvalid, 1'b0);
    tick;
    sample;
    check("t5_araddr", m.araddr, 32'h50);
    check("t5_no_replay", m.awvalid, 1'b0);
    tick;
    s1.arvalid = 0; m.rvalid = 1; m.rdata = 32'hA5A5A5A5;
    sample;
    check("t5_s1_rvalid", s1.rvalid, 1'b1);
    check("t5_s1_rdata", s1.rdata, 32'hA5A5A5A5);
    tick;
    m.rvalid = 0;

    // s0 read stalled by rready=0 while s1 waits
    s0.araddr = 32'h60; s0.arvalid = 1; s0.rready = 0;
    tick;
    sample;
    check("t6_araddr", m.araddr, 32'h60);
    tick;
    s0.arvalid = 0; m.rvalid = 1; m.rdata = 32'hBEEF0001;
    s1.araddr = 32'h70; s1.arvalid = 1; s1.rready = 1;
    for (int i = 0; i < 5; i++) begin
      sample;
      check("t6_hold_s0_rvalid", s0.rvalid, 1'b1);
      check("t6_hold_s0_rdata", s0.rdata, 32'hBEEF0001);
      check("t6_hold_s1_arready", s1.arready, 1'b0);
      check("t6_hold_m_arvalid", m.arvalid, 1'b0);
      check("t6_hold_m_rready", m.rready, 1'b0);
      tick;
    end
    s0.rready = 1;
    sample;
    check("t6_rready", m.rready, 1'b1);
    tick;
    m.rvalid = 0; s0.rready = 0;
    sample;
    check("t6_idle_arvalid", m.arvalid, 1'b0);
    tick;
    sample;
    check("t6_s1_araddr", m.araddr, 32'h70);
    check("t6_s1_arready", s1.arready, 1'b1);
    tick;
    s1.arvalid = 0; m.rvalid = 1; m.rdata = 32'h7;
    sample;
    check("t6_s1_rdata", s1.rdata, 32'h7);
    check("t6_s0_rdata", s0.rdata, 32'h0);
    tick;
    m.rvalid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
